// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_DATA   = 1;

  // A single-port arbiter still carries a 1-bit grant index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checks on the upstream request ports.
module mem_port_arbiter_chk #(
  parameter int NUM_PORTS = 2
) (
  input logic                 clk,
  input logic                 rst,
  input logic [NUM_PORTS-1:0] req_read,
  input logic [NUM_PORTS-1:0] req_write
);

  a_no_read_and_write: assert property (@(posedge clk) disable iff (rst)
    ((req_read & req_write) == '0));

endmodule

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational winner selection: round-robin from a pointer, or lowest index first.
module rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_rr_ptr,
  input  logic                 i_mode,
  output logic                 o_valid,
  output logic [IDX_W-1:0]     o_idx
);

  // Scan from the far end so the nearest requester overwrites the result last.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    if (i_mode) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        o_idx = i_req[i] ? IDX_W'(i) : o_idx;
      end
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        o_idx = i_req[IDX_W'((int'(i_rr_ptr) + k) % NUM_PORTS)]
              ? IDX_W'((int'(i_rr_ptr) + k) % NUM_PORTS) : o_idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-to-1 memory request arbiter; one downstream transaction outstanding at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MASK_WIDTH    = DATA_WIDTH / 8,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_wmask,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             resp,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [MASK_WIDTH-1:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_resp,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  arb_state_t             r_state;
  arb_state_t             w_next_state;
  logic [IDX_W-1:0]       r_grant;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       w_ptr_next;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_win_valid;
  logic [NUM_PORTS-1:0]   w_req;
  logic                   w_done;
  logic                   r_mem_read;
  logic                   r_mem_write;
  logic [MASK_WIDTH-1:0]  r_mem_wmask;
  logic [ADDR_WIDTH-1:0]  r_mem_address;
  logic [DATA_WIDTH-1:0]  r_mem_wdata;

  assign w_req      = req_read | req_write;
  assign w_done     = (r_state == BUSY) && mem_resp;
  assign w_ptr_next = (int'(r_grant) == NUM_PORTS - 1) ? '0 : r_grant + 1'b1;

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_wmask   = r_mem_wmask;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .i_mode   (PRIORITY_MODE != 0),
    .o_valid  (w_win_valid),
    .o_idx    (w_win_idx)
  );

  mem_port_arbiter_chk #(
    .NUM_PORTS (NUM_PORTS)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_read  (req_read),
    .req_write (req_write)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_win_valid ? BUSY : IDLE;
      BUSY:    w_next_state = mem_resp ? IDLE : BUSY;
      default: w_next_state = IDLE;
    endcase
  end

  // A simultaneous read+write request is forwarded as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_wmask   <= '0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else if ((r_state == IDLE) && w_win_valid) begin
      r_grant       <= w_win_idx;
      r_mem_write   <= req_write[w_win_idx];
      r_mem_read    <= req_read[w_win_idx] & ~req_write[w_win_idx];
      r_mem_wmask   <= req_wmask[int'(w_win_idx)*MASK_WIDTH +: MASK_WIDTH];
      r_mem_address <= req_address[int'(w_win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      r_mem_wdata   <= req_wdata[int'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
    end else if (w_done) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_rr_ptr      <= w_ptr_next;
    end
  end

  always_comb begin
    resp  = '0;
    rdata = '0;
    if (w_done) begin
      resp[r_grant]                                = 1'b1;
      rdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
    end else begin
      resp  = '0;
      rdata = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority 3-port arbiter with a latency-3 memory model.
module tb_mem_port_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          cyc;
    int          gap;
  } mem_exp_t;

  typedef struct {
    logic [2:0]  resp;
    logic [95:0] rdata;
    int          cyc;
  } resp_exp_t;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req_read    [2];
  logic [NP-1:0]     req_write   [2];
  logic [NP*MW-1:0]  req_wmask   [2];
  logic [NP*AW-1:0]  req_address [2];
  logic [NP*DW-1:0]  req_wdata   [2];
  logic [NP-1:0]     resp        [2];
  logic [NP*DW-1:0]  rdata       [2];
  logic              mem_read    [2];
  logic              mem_write   [2];
  logic [MW-1:0]     mem_wmask   [2];
  logic [AW-1:0]     mem_address [2];
  logic [DW-1:0]     mem_wdata   [2];
  logic              mem_resp    [2];
  logic [DW-1:0]     mem_rdata   [2];

  bit                auto_mem  [2];
  bit                man_resp  [2];
  logic [31:0]       man_rdata [2];

  int          rem    [2][NP];
  bit          p_wr   [2][NP];
  logic [31:0] p_addr [2][NP];
  logic [31:0] p_wdat [2][NP];
  logic [3:0]  p_mask [2][NP];

  mem_exp_t  exp_mem  [2][$];
  resp_exp_t exp_resp [2][$];

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                     .PRIORITY_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .req_read(req_read[0]), .req_write(req_write[0]),
    .req_wmask(req_wmask[0]), .req_address(req_address[0]), .req_wdata(req_wdata[0]),
    .resp(resp[0]), .rdata(rdata[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_wmask(mem_wmask[0]), .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]),
    .mem_resp(mem_resp[0]), .mem_rdata(mem_rdata[0]));

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                     .PRIORITY_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .req_read(req_read[1]), .req_write(req_write[1]),
    .req_wmask(req_wmask[1]), .req_address(req_address[1]), .req_wdata(req_wdata[1]),
    .resp(resp[1]), .rdata(rdata[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_wmask(mem_wmask[1]), .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]),
    .mem_resp(mem_resp[1]), .mem_rdata(mem_rdata[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'hDEAD_AEEF;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    ncmp++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic set_port(input int d, input int p, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdat, input logic [3:0] mask, input int n);
    p_wr[d][p]   = wr;
    p_addr[d][p] = addr;
    p_wdat[d][p] = wdat;
    p_mask[d][p] = mask;
    rem[d][p]    = n;
  endtask

  task automatic apply_reqs(input int d);
    for (int p = 0; p < NP; p++) begin
      req_read[d][p]              = (rem[d][p] > 0) && !p_wr[d][p];
      req_write[d][p]             = (rem[d][p] > 0) && p_wr[d][p];
      req_address[d][p*AW +: AW]  = p_addr[d][p];
      req_wdata[d][p*DW +: DW]    = p_wdat[d][p];
      req_wmask[d][p*MW +: MW]    = p_mask[d][p];
    end
  endtask

  task automatic push_mem(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdat, input logic [3:0] mask, input int c, input int gap);
    mem_exp_t e;
    e.rd = !wr; e.wr = wr; e.addr = addr; e.wdata = wdat; e.mask = mask; e.cyc = c; e.gap = gap;
    exp_mem[d].push_back(e);
  endtask

  task automatic push_resp(input int d, input int p, input logic [31:0] addr, input int c);
    resp_exp_t r;
    r.resp  = 3'b001 << p;
    r.rdata = {64'h0, mem_model(addr)} << (p * 32);
    r.cyc   = c;
    exp_resp[d].push_back(r);
  endtask

  task automatic run(input int d, input int max_cyc);
    int n;
    int left;
    n = 0;
    apply_reqs(d);
    left = 1;
    while (left > 0 && n < max_cyc) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) if (resp[d][p] && rem[d][p] > 0) rem[d][p]--;
      @(posedge clk); #1;
      apply_reqs(d);
      n++;
      left = 0;
      for (int p = 0; p < NP; p++) left += rem[d][p];
    end
    check($sformatf("d%0d_requests_drained", d), 128'(left), 128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Memory model: responds three cycles after a new strobe, or follows manual control.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    initial begin
      bit busy;
      int cnt;
      busy = 1'b0;
      cnt = 0;
      mem_resp[g] = 1'b0;
      mem_rdata[g] = 32'h0;
      forever begin
        @(posedge clk); #2;
        if (!auto_mem[g]) begin
          busy = 1'b0;
          mem_resp[g] = man_resp[g];
          mem_rdata[g] = man_rdata[g];
        end else if (mem_resp[g]) begin
          mem_resp[g] = 1'b0;
          mem_rdata[g] = 32'h0;
          busy = 1'b0;
        end else if (!busy && (mem_read[g] || mem_write[g])) begin
          busy = 1'b1;
          cnt = 0;
        end else if (busy) begin
          cnt++;
          if (cnt == 3) begin
            mem_resp[g] = 1'b1;
            mem_rdata[g] = mem_model(mem_address[g]);
          end
        end
      end
    end
  end

  // Scoreboard monitor: checks every new downstream request, its stability, and every resp.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin
      mem_exp_t  e;
      resp_exp_t r;
      bit        prev;
      logic [69:0] latched;
      logic [69:0] cur;
      int        last_resp_cyc;
      prev = 1'b0;
      latched = '0;
      last_resp_cyc = -100;
      forever begin
        @(negedge clk);
        cur = {mem_read[g], mem_write[g], mem_address[g], mem_wdata[g], mem_wmask[g]};
        if (!rst) begin
          if ((mem_read[g] || mem_write[g]) && !prev) begin
            if (exp_mem[g].size() == 0) begin
              ncmp++; nfail++;
              $display("FAIL d%0d_unexpected_mem: got addr %h expected no request", g, mem_address[g]);
            end else begin
              e = exp_mem[g].pop_front();
              check($sformatf("d%0d_mem_req", g), 128'(cur),
                    128'({e.rd, e.wr, e.addr, e.wdata, e.mask}));
              if (e.cyc >= 0) check($sformatf("d%0d_req_latency", g), 128'(cyc), 128'(e.cyc));
              if (e.gap >= 0) check($sformatf("d%0d_idle_gap", g), 128'(cyc - last_resp_cyc), 128'(e.gap));
            end
            latched = cur;
          end else if ((mem_read[g] || mem_write[g]) && prev) begin
            check($sformatf("d%0d_mem_stable", g), 128'(cur), 128'(latched));
          end
          if (resp[g] != 3'b000) begin
            check($sformatf("d%0d_strobe_at_resp", g), 128'(mem_read[g] | mem_write[g]), 128'(1));
            if (exp_resp[g].size() == 0) begin
              ncmp++; nfail++;
              $display("FAIL d%0d_unexpected_resp: got resp %b expected none", g, resp[g]);
            end else begin
              r = exp_resp[g].pop_front();
              check($sformatf("d%0d_resp", g), 128'(resp[g]), 128'(r.resp));
              check($sformatf("d%0d_rdata", g), 128'(rdata[g]), 128'(r.rdata));
              if (r.cyc >= 0) check($sformatf("d%0d_resp_latency", g), 128'(cyc), 128'(r.cyc));
            end
            last_resp_cyc = cyc;
          end
        end
        prev = mem_read[g] || mem_write[g];
      end
    end
  end

  initial begin
    int c0;
    int n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      auto_mem[d] = 1'b1;
      man_resp[d] = 1'b0;
      man_rdata[d] = 32'h0;
      for (int p = 0; p < NP; p++) set_port(d, p, 1'b0, 32'h0, 32'h0, 4'h0, 0);
      apply_reqs(d);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_reset_mem", d),
            128'({mem_read[d], mem_write[d], mem_address[d], mem_wdata[d], mem_wmask[d]}), 128'(0));
      check($sformatf("d%0d_reset_resp", d), 128'({resp[d], rdata[d]}), 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Simultaneous read (port 0) and write (port 1): port 0 first, one idle cycle between.
    set_port(0, 0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1);
    set_port(0, 1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 1);
    push_mem(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, -1, -1);
    push_mem(0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, -1, 2);
    push_resp(0, 0, 32'h0000_0100, -1);
    push_resp(0, 1, 32'h0000_0200, -1);
    run(0, 40);

    // Single read with exact latency: strobe one cycle after request, resp three later.
    c0 = cyc;
    set_port(0, 0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 1);
    push_mem(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, c0 + 1, -1);
    push_resp(0, 0, 32'h0000_1000, c0 + 4);
    run(0, 20);

    // Round-robin fairness from a fresh pointer: 0,1,2 repeated three times.
    do_reset();
    for (int p = 0; p < NP; p++) set_port(0, p, 1'b0, 32'h0000_3000 + 32'(p * 16), 32'h0, 4'h0, 3);
    for (int t = 0; t < 9; t++) begin
      push_mem(0, 1'b0, 32'h0000_3000 + 32'((t % 3) * 16), 32'h0, 4'h0, -1, (t == 0) ? -1 : 2);
      push_resp(0, t % 3, 32'h0000_3000 + 32'((t % 3) * 16), -1);
    end
    run(0, 200);

    // Fixed priority: port 0 wins all three of its transactions before ports 1 and 2.
    for (int p = 0; p < NP; p++) set_port(1, p, 1'b0, 32'h0000_4000 + 32'(p * 16), 32'h0, 4'h0, (p == 0) ? 3 : 1);
    for (int t = 0; t < 5; t++) begin
      n = (t < 3) ? 0 : t - 2;
      push_mem(1, 1'b0, 32'h0000_4000 + 32'(n * 16), 32'h0, 4'h0, -1, (t == 0) ? -1 : 2);
      push_resp(1, n, 32'h0000_4000 + 32'(n * 16), -1);
    end
    run(1, 200);

    // Port 1 drops its write while granted: latched values complete and resp still pulses.
    set_port(0, 1, 1'b1, 32'h0000_0600, 32'hCAFE_F00D, 4'h3, 1);
    push_mem(0, 1'b1, 32'h0000_0600, 32'hCAFE_F00D, 4'h3, -1, -1);
    push_resp(0, 1, 32'h0000_0600, -1);
    apply_reqs(0);
    n = 0;
    while (!mem_write[0] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("d0_write_granted", 128'(mem_write[0]), 128'(1));
    set_port(0, 1, 1'b0, 32'hBAD0_0000, 32'h0, 4'h0, 0);
    apply_reqs(0);
    repeat (8) @(posedge clk);
    #1;

    // Reset during BUSY, late mem_resp two cycles later, then arbitration restarts at port 0.
    auto_mem[0] = 1'b0;
    set_port(0, 2, 1'b0, 32'h0000_2500, 32'h0, 4'h0, 1);
    push_mem(0, 1'b0, 32'h0000_2500, 32'h0, 4'h0, -1, -1);
    apply_reqs(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    set_port(0, 2, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    apply_reqs(0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("d0_rst_drops_strobe", 128'({mem_read[0], mem_write[0]}), 128'(0));
    @(posedge clk); #1;
    man_resp[0] = 1'b1;
    man_rdata[0] = 32'h5555_AAAA;
    @(negedge clk);
    check("d0_late_resp_ignored", 128'({resp[0], rdata[0]}), 128'(0));
    @(posedge clk); #1;
    man_resp[0] = 1'b0;
    man_rdata[0] = 32'h0;
    @(posedge clk); #1;
    auto_mem[0] = 1'b1;
    set_port(0, 1, 1'b0, 32'h0000_2100, 32'h0, 4'h0, 1);
    set_port(0, 2, 1'b0, 32'h0000_2200, 32'h0, 4'h0, 1);
    push_mem(0, 1'b0, 32'h0000_2100, 32'h0, 4'h0, -1, -1);
    push_mem(0, 1'b0, 32'h0000_2200, 32'h0, 4'h0, -1, 2);
    push_resp(0, 1, 32'h0000_2100, -1);
    push_resp(0, 2, 32'h0000_2200, -1);
    run(0, 60);

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_mem_queue_empty", d), 128'(exp_mem[d].size()), 128'(0));
      check($sformatf("d%0d_resp_queue_empty", d), 128'(exp_resp[d].size()), 128'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
N-to-1 memory request arbiter for the rv32i pipeline. It merges the instruction-fetch port, the data port and any future requesters (prefetcher, DMA) onto one physical-memory/L2 port. It generalises the fixed two-port (A read-only, B read/write) memory interface of the current CPU to NUM_PORTS identical read/write ports. The grant policy is selectable: round-robin or fixed priority. Exactly one transaction is outstanding downstream at a time.

Parameters:
NUM_PORTS, 2, number of upstream requesters (>=1); port 0 = instruction fetch, port 1 = data.
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width (multiple of 8).
MASK_WIDTH, DATA_WIDTH/8, byte write-mask width.
PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
req_read  input  NUM_PORTS  per-port read request; level, held until that port's resp.
req_write  input  NUM_PORTS  per-port write request; level, held until resp.
req_wmask  input  NUM_PORTS*MASK_WIDTH  per-port byte mask; slice i at [i*MASK_WIDTH +: MASK_WIDTH].
req_address  input  NUM_PORTS*ADDR_WIDTH  per-port address; slice i.
req_wdata  input  NUM_PORTS*DATA_WIDTH  per-port write data; slice i.
resp  output  NUM_PORTS  one-cycle completion pulse per port.
rdata  output  NUM_PORTS*DATA_WIDTH  per-port read data; valid only with resp[i].
mem_read  output  1  downstream read strobe, held until mem_resp.
mem_write  output  1  downstream write strobe, held until mem_resp.
mem_wmask  output  MASK_WIDTH  downstream byte mask.
mem_address  output  ADDR_WIDTH  downstream address.
mem_wdata  output  DATA_WIDTH  downstream write data.
mem_resp  input  1  downstream completion, one-cycle pulse.
mem_rdata  input  DATA_WIDTH  downstream read data, valid with mem_resp.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0. mem_read, mem_write, mem_wmask, mem_address, mem_wdata, resp and rdata are all 0.
- A port is requesting when req_read[i] | req_write[i].
- IDLE: if any port requests, pick a winner and register its address, wdata, wmask and op into the mem_* registers. Go to BUSY. mem_* strobes are therefore asserted the cycle after the request is first seen, a fixed 1-cycle arbitration latency.
- Winner selection, round-robin: the first requesting index at or above rr_ptr, wrapping modulo NUM_PORTS.
- Winner selection, fixed priority: the lowest requesting index.
- BUSY: mem_* outputs stay stable. mem_resp is ignored in every state except BUSY.
- On mem_resp in BUSY: resp[grant]=1 combinationally in the same cycle and rdata slice grant = mem_rdata. All other resp bits and rdata slices are 0.
- On that same edge: clear mem_read and mem_write, set rr_ptr=(grant+1) mod NUM_PORTS, go to IDLE.
- Back-to-back: a port that is granted again re-arbitrates in IDLE. Minimum spacing between successive mem requests is 1 idle cycle.
- In round-robin mode, no requester waits more than NUM_PORTS-1 other transactions.
- req_read and req_write both high on one port is illegal. The write is forwarded, and a simulation assertion fires.
- A port that drops its request while granted does not abort the transaction. It completes on the latched values and resp still pulses.
- Request inputs of non-granted ports may change freely.
- rst during BUSY: return to IDLE and drop strobes on the next edge. A late mem_resp is ignored and no resp is generated.
- NUM_PORTS=1: the arbiter degenerates to a registered pass-through with the same latency. Grant index width is max(1,$clog2(NUM_PORTS)).

Decomposition:
- Add arb_state_t (IDLE, BUSY) to the shared rv32i_types package, plus a localparam for the default port indices: PORT_IFETCH=0, PORT_DATA=1.
- One sub-module, rr_picker. It is combinational: inputs are the request vector, rr_ptr and mode; outputs are a valid flag and the winner index. Reuse it for future cache-line arbiters.

Test Plan:
1. Single read, port 0 address 0x0000_1000. Expect mem_read at cycle 1 with mem_address=0x1000. Mem returns mem_rdata=0xDEADBEEF at cycle 4 -> resp[0]=1 and rdata0=0xDEADBEEF in cycle 4, resp[1]=0.
2. Simultaneous requests, round-robin: port 0 reads 0x100 and port 1 writes 0x200 with wdata=0x12345678, wmask=0xF. Expect port 0 served first, then the port 1 write with mem_wdata=0x12345678 and mem_wmask=0xF, with 1 idle cycle between.
3. Fairness, NUM_PORTS=3, PRIORITY_MODE=0: all ports request continuously for 9 transactions -> grant order 0,1,2,0,1,2,0,1,2.
4. Fixed priority, PRIORITY_MODE=1, all ports requesting continuously for 3 transactions -> every grant goes to port 0.
5. rst asserted during BUSY, then mem_resp pulsed 2 cycles later -> mem_read=0 after the edge, no resp pulse, and the next arbitration starts at rr_ptr=0.
6. Port 1 deasserts write mid-BUSY -> mem_write stays high with the latched address and data until mem_resp, and resp[1] still pulses once.
